// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine: one micro-rotation per clock, valid/ready in and out.
// Rotation (mode=0) drives z toward 0; vectoring (mode=1) drives y toward 0.
module cordic_iter_engine #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ITER  = 11
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    mode,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] z_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] z_out,
  output logic                    busy,
  output logic [3:0]              iter_idx
);

  localparam int unsigned IW = WIDTH + 2;
  localparam logic signed [IW-1:0] SAT_MAX = IW'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [IW-1:0] SAT_MIN = IW'(-(1 << (WIDTH - 1)));
  localparam logic [3:0] LAST_IDX = 4'(ITER - 1);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t state, state_next;
  logic signed [IW-1:0] x_q, y_q, z_q, x_d, y_d, z_d;
  logic                 mode_q, mode_d;
  logic [3:0]           idx_d;
  logic                 in_ready_d, out_valid_d, busy_d;
  logic signed [WIDTH-1:0] x_out_d, y_out_d, z_out_d;

  logic signed [IW-1:0] x_sh, y_sh, atan_i, x_rot, y_rot, z_rot;
  logic                 dir_pos;

  // arctan(2^-i) in Q2.13; the last two entries round to zero
  function automatic logic signed [IW-1:0] atan_lut(input logic [3:0] i);
    case (i)
      4'd0:    atan_lut = IW'(6434);
      4'd1:    atan_lut = IW'(3798);
      4'd2:    atan_lut = IW'(2007);
      4'd3:    atan_lut = IW'(1019);
      4'd4:    atan_lut = IW'(511);
      4'd5:    atan_lut = IW'(256);
      4'd6:    atan_lut = IW'(128);
      4'd7:    atan_lut = IW'(64);
      4'd8:    atan_lut = IW'(32);
      4'd9:    atan_lut = IW'(16);
      4'd10:   atan_lut = IW'(8);
      4'd11:   atan_lut = IW'(4);
      4'd12:   atan_lut = IW'(2);
      4'd13:   atan_lut = IW'(1);
      default: atan_lut = '0;
    endcase
  endfunction

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [IW-1:0] v);
    if (v > SAT_MAX)      sat = SAT_MAX[WIDTH-1:0];
    else if (v < SAT_MIN) sat = SAT_MIN[WIDTH-1:0];
    else                  sat = v[WIDTH-1:0];
  endfunction

  // One micro-rotation from the current (pre-update) register values
  always_comb begin
    x_sh    = x_q >>> iter_idx;
    y_sh    = y_q >>> iter_idx;
    atan_i  = atan_lut(iter_idx);
    dir_pos = mode_q ? y_q[IW-1] : ~z_q[IW-1];
    x_rot   = dir_pos ? (x_q - y_sh)   : (x_q + y_sh);
    y_rot   = dir_pos ? (y_q + x_sh)   : (y_q - x_sh);
    z_rot   = dir_pos ? (z_q - atan_i) : (z_q + atan_i);
  end

  always_comb begin
    state_next  = state;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    mode_d      = mode_q;
    idx_d       = iter_idx;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;
    busy_d      = busy;
    x_out_d     = x_out;
    y_out_d     = y_out;
    z_out_d     = z_out;
    case (state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          x_d        = IW'(x_in);
          y_d        = IW'(y_in);
          z_d        = IW'(z_in);
          mode_d     = mode;
          idx_d      = 4'd0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_next = S_ITER;
        end
      end
      S_ITER: begin
        x_d = x_rot;
        y_d = y_rot;
        z_d = z_rot;
        if (iter_idx == LAST_IDX) begin
          idx_d       = 4'd0;
          out_valid_d = 1'b1;
          x_out_d     = sat(x_rot);
          y_out_d     = sat(y_rot);
          z_out_d     = sat(z_rot);
          state_next  = S_DONE;
        end else begin
          idx_d = iter_idx + 4'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
          state_next  = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        in_ready_d  = 1'b1;
        idx_d       = 4'd0;
        state_next  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      mode_q    <= 1'b0;
      iter_idx  <= 4'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
    end else begin
      state     <= state_next;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      mode_q    <= mode_d;
      iter_idx  <= idx_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      x_out     <= x_out_d;
      y_out     <= y_out_d;
      z_out     <= z_out_d;
    end
  end

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Directed bench for cordic_iter_engine; expected results were stepped through by hand
// with floor-rounding arithmetic shifts, matching the 11-iteration default.
module tb_cordic_iter_engine;

  localparam int NITER = 11;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, mode, out_valid, out_ready, busy;
  logic signed [15:0] x_in, y_in, z_in, x_out, y_out, z_out;
  logic [3:0] iter_idx;

  int total = 0;
  int bad   = 0;

  cordic_iter_engine #(.WIDTH(16), .ITER(11)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out), .busy(busy), .iter_idx(iter_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int obs, input int exp, input int tol = 0);
    total++;
    if ((obs - exp > tol) || (exp - obs > tol)) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operand set and return just after the accepting edge
  task automatic accept(input string tag, input int x, input int y, input int z,
                        input logic m, input logic hold);
    logic rdy;
    int n;
    n = 0;
    x_in = 16'(x); y_in = 16'(y); z_in = 16'(z); mode = m; in_valid = 1'b1;
    do begin
      rdy = in_ready;
      tick();
      n++;
    end while (!rdy && n < 40);
    chk({tag, "_accept"}, int'(rdy), 1);
    chk({tag, "_busy"}, int'(busy), 1);
    if (!hold) begin
      in_valid = 1'b0;
      mode = ~m; x_in = 16'sh1357; y_in = -16'sh2468; z_in = 16'sh0abc;
    end
  endtask

  task automatic wait_result(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      chk({tag, "_idx"}, int'(iter_idx), n);
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, NITER);
    chk({tag, "_rdy_done"}, int'(in_ready), 0);
  endtask

  task automatic check_out(input string tag, input int ex, input int ey, input int ez,
                           input int tol);
    chk({tag, "_x"}, int'(x_out), ex, tol);
    chk({tag, "_y"}, int'(y_out), ey, tol);
    chk({tag, "_z"}, int'(z_out), ez, tol);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ov_drop"}, int'(out_valid), 0);
    chk({tag, "_rdy_back"}, int'(in_ready), 1);
    chk({tag, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;
    repeat (3) tick();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_idx", int'(iter_idx), 0);
    chk("rst_x", int'(x_out), 0);
    reset = 1'b0;
    tick();

    // Rotation by +pi/4 with gain pre-scaled x
    accept("rot", 4975, 0, 6434, 1'b0, 1'b0);
    wait_result("rot");
    check_out("rot", 5795, 5789, 3, 0);
    drain("rot");

    accept("neg", 4975, 0, -6434, 1'b0, 1'b0);
    wait_result("neg");
    check_out("neg", 5790, -5795, 3, 0);
    drain("neg");

    accept("vec", 8192, 8192, 0, 1'b1, 1'b0);
    wait_result("vec");
    check_out("vec", 19078, 7, 6431, 0);
    drain("vec");

    // Saturation at both rails; z only needs to be near zero
    accept("sat_hi", 30000, 30000, 0, 1'b0, 1'b0);
    wait_result("sat_hi");
    check_out("sat_hi", 32767, 32767, 0, 8);
    drain("sat_hi");

    accept("sat_lo", -30000, -30000, 0, 1'b0, 1'b0);
    wait_result("sat_lo");
    check_out("sat_lo", -32768, -32768, 0, 8);
    drain("sat_lo");

    // Backpressure: result held, new operands refused
    accept("bp", 4975, 0, 6434, 1'b0, 1'b0);
    wait_result("bp");
    in_valid = 1'b1; mode = 1'b1; x_in = 16'sd8192; y_in = 16'sd8192; z_in = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_ov", int'(out_valid), 1);
      chk("bp_hold_x", int'(x_out), 5795);
      chk("bp_hold_y", int'(y_out), 5789);
      chk("bp_hold_rdy", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    drain("bp");
    tick();
    chk("bp_no_capture", int'(busy), 0);

    // Reset in the middle of an operation
    accept("mid", 8192, 8192, 0, 1'b1, 1'b0);
    n = 0;
    while (iter_idx != 4'd5 && n < 20) begin
      tick();
      n++;
    end
    chk("mid_reach_idx5", int'(iter_idx), 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_ov", int'(out_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_idx", int'(iter_idx), 0);
    chk("mid_rst_rdy", int'(in_ready), 1);
    chk("mid_rst_x", int'(x_out), 0);
    repeat (NITER + 2) tick();
    chk("mid_no_partial", int'(out_valid), 0);
    accept("post", 4975, 0, 6434, 1'b0, 1'b0);
    wait_result("post");
    check_out("post", 5795, 5789, 3, 0);
    drain("post");

    // Back-to-back with in_valid and out_ready held high
    out_ready = 1'b1;
    accept("b2b_a", 4975, 0, 6434, 1'b0, 1'b1);
    x_in = 16'sd4975; y_in = 16'sd0; z_in = -16'sd6434; mode = 1'b0;
    wait_result("b2b_a");
    check_out("b2b_a", 5795, 5789, 3, 0);
    tick();
    chk("b2b_gap_ov", int'(out_valid), 0);
    chk("b2b_gap_rdy", int'(in_ready), 1);
    tick();
    chk("b2b_b_busy", int'(busy), 1);
    in_valid = 1'b0; x_in = '0; mode = 1'b1;
    wait_result("b2b_b");
    check_out("b2b_b", 5790, -5795, 3, 0);
    drain("b2b_b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cordic_iter_engine.md
Name: cordic_iter_engine

Overview:
Iterative CORDIC datapath with its own iteration sequencer. Consumes an (x, y, z) operand set through a valid/ready input handshake and runs ITER micro-rotations, one per clock. Each micro-rotation is indexed by a 4-bit iteration counter. The three operand registers load from the inputs on iteration 0 and from their own feedback on every later iteration. The result set is presented through a valid/ready output handshake to the NN activation stage.

Parameters:
WIDTH, 16, signed operand/result width; x, y, z all Q2.13 (z in radians)
ITER, 11, micro-rotations per operation; legal 1..16

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand set present
in_ready  output  1  engine can accept operands (IDLE only)
mode  input  1  0 = rotation, 1 = vectoring; sampled at accept
x_in  input  WIDTH  signed x operand
y_in  input  WIDTH  signed y operand
z_in  input  WIDTH  signed angle operand
out_valid  output  1  result set valid
out_ready  input  1  downstream accepts result
x_out  output  WIDTH  signed x result, not gain-compensated
y_out  output  WIDTH  signed y result
z_out  output  WIDTH  signed residual angle
busy  output  1  high in ITER or DONE
iter_idx  output  4  current micro-rotation index (0 outside ITER)

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, iter_idx=0, x/y/z regs and outputs=0. Reset wins over every other event in the same cycle.
- State IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: load sign-extended x_in/y_in/z_in into internal regs (WIDTH+2 bits, 2 guard bits), latch mode, iter_idx=0, go to ITER.
- State ITER, one micro-rotation per cycle at index i=iter_idx:
  - Rotation mode: d=+1 if z>=0, else -1.
  - Vectoring mode: d=+1 if y<0, else -1.
  - Update: x'=x-d*(y>>>i), y'=y+d*(x>>>i), z'=z-d*ATAN[i]. The shift is arithmetic and all terms use the pre-update values.
  - ATAN ROM (Q2.13) for i=0..15: 6434,3798,2007,1019,511,256,128,64,32,16,8,4,2,1,0,0.
  - iter_idx increments each cycle. After the update at i=ITER-1, go to DONE and clear iter_idx to 0.
- State DONE:
  - out_valid=1.
  - x_out/y_out/z_out are the internal regs saturated to signed WIDTH, i.e. clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Outputs are registered and stay stable while out_valid=1 and out_ready=0.
  - On out_ready, go to IDLE; out_valid drops on the next edge.
- Latency: the accept edge plus ITER cycles gives the first cycle with out_valid=1 (11 cycles at default).
- Throughput: one operation per ITER+2 cycles maximum. in_ready=0 throughout ITER and DONE.
- in_valid while busy: ignored; operands not captured; upstream must hold them.
- out_ready while not out_valid: no effect.
- Reset mid-ITER or mid-DONE: operation is discarded and no partial result is emitted. in_ready=1 on the cycle after reset deasserts.
- mode and operand changes after accept have no effect on the running operation.
- Gain: the K≈0.60725 (4975 Q2.13) compensation is the caller's responsibility, applied by pre-scaling x_in.

Test Plan:
- Rotation: x_in=4975, y_in=0, z_in=6434 (π/4), mode=0 -> out_valid 11 cycles after accept; x_out≈5793, y_out≈5793 (±8 LSB); |z_out|≤8.
- Negative angle: x_in=4975, y_in=0, z_in=-6434 -> x_out≈5793, y_out≈-5793 (±8).
- Vectoring: x_in=8192, y_in=8192, z_in=0, mode=1 -> z_out≈6434 (±8), x_out≈19078 (±16), |y_out|≤8.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs constant, in_ready=0, a new in_valid is not accepted; raise out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-operation: assert reset at iter_idx=5 -> next cycle out_valid=0, busy=0, iter_idx=0, in_ready=1. A following operation completes correctly.
- Back-to-back: keep in_valid=1 with a new operand set while out_ready=1 -> second accept occurs in the IDLE cycle after DONE; two result sets are correct and in order; iter_idx sequence is 0..10 per operation.
